alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters (req0, req1) using valid/ready handshakes. Each accepted operation is latched, driven onto the ALU for one cycle, and returned as a registered result tagged with the requester id. The block sits between the ALU and the clients that need extra ALU bandwidth: the main datapath's execute stage and a secondary unit such as an address generator or multi-cycle sequencer.

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Each accepted operation is latched, presented to the ALU for one cycle
// (EXEC), and returned as a registered result tagged with the requester id
// (RESP). A response handshake and a new accept can share one edge, giving one
// op every two cycles when rsp_ready is held high.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins ties, no last-grant register). Default build is round-robin.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   reqN_valid / reqN_ready        request handshake, N = 0, 1 (ready is combinational)
//   reqN_a, reqN_b                 operands (DATA_W)
//   reqN_shamt, reqN_op            shift amount (5), ALU op code (5)
//   alu_a, alu_b, alu_shamt, alu_op   operands driven to the external ALU
//   alu_result                     combinational ALU result
//   rsp_valid / rsp_ready          response handshake
//   rsp_id, rsp_data               requester id and result value
module alu_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [4:0]        req0_shamt,
    input  logic [4:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req1_shamt,
    input  logic [4:0]        req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [4:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [SHAMT_W-1:0]   r_shamt;
    logic [OP_W-1:0]      r_op;
    logic                 r_id;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [DATA_W-1:0]    r_rsp_data;

    logic                 w_can_accept;
    logic                 w_any_valid;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;

    assign w_any_valid = req0_valid | req1_valid;

    // Arbitration: pick a winner among the valids, independent of state.
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid & ~req0_valid;
    end
`else
    logic r_last_id;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | r_last_id);
        w_grant1 = req1_valid & (~req0_valid | ~r_last_id);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_id <= 1'b1;
        end else if (w_accept) begin
            r_last_id <= w_grant1;
        end
    end
`endif

    // Next-state logic; accepting is allowed in IDLE and in a completing RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_can_accept = ~reset;
                if (w_any_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_can_accept = ~reset;
                    w_state_nxt  = w_any_valid ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept   = w_can_accept & w_any_valid;
    assign req0_ready = w_can_accept & w_grant0;
    assign req1_ready = w_can_accept & w_grant1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers: only written on accept, so the ALU inputs stay quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_shamt <= '0;
            r_op    <= '0;
            r_id    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= w_grant1 ? req1_a     : req0_a;
            r_b     <= w_grant1 ? req1_b     : req0_b;
            r_shamt <= w_grant1 ? req1_shamt : req0_shamt;
            r_op    <= w_grant1 ? req1_op    : req0_op;
            r_id    <= w_grant1;
        end
    end

    // Response registers: result captured at the end of EXEC, held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (w_state_nxt == S_RESP);
            if (r_state == S_EXEC) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= alu_result;
            end
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_shamt = r_shamt;
    assign alu_op    = r_op;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (combinational readies #1 after the inputs change).
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLT = 5'd2;
    localparam logic [4:0] OP_SLL = 5'd3;
    localparam logic [4:0] OP_BAD = 5'd31;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [4:0]        req0_shamt, req0_op;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [4:0]        req1_shamt, req1_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [4:0]        alu_shamt, alu_op;
    logic              rsp_valid, rsp_ready, rsp_id;
    logic [DATA_W-1:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    // Reference ALU; unknown op codes return 0.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            OP_SLL:  alu_result = alu_b << alu_shamt;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [4:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_shamt = sh; req0_op = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [4:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_shamt = sh; req1_op = op;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rsp_ready = 1'b1;
        drive0(1'b1, 32'd9, 32'd9, 5'd0, OP_ADD);
        drive1(1'b1, 32'd9, 32'd9, 5'd0, OP_ADD);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got=%0h exp=0", rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin failures++; $display("FAIL reset_alu_ab got=%0h/%0h exp=0/0", alu_a, alu_b); end
        checks++; if (alu_op !== 5'd0 || alu_shamt !== 5'd0) begin failures++; $display("FAIL reset_alu_op got=%0h/%0h exp=0/0", alu_op, alu_shamt); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_readies got=%0b%0b exp=00", req0_ready, req1_ready); end
        drive0(1'b0, 32'd0, 32'd0, 5'd0, OP_ADD);
        drive1(1'b0, 32'd0, 32'd0, 5'd0, OP_ADD);
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b1;
        drive0(1'b1, 32'd5, 32'd7, 5'd0, OP_ADD);
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready0 got=%0b exp=1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready1 got=%0b exp=0", req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin failures++; $display("FAIL single_exec_alu got=%0h/%0h exp=5/7", alu_a, alu_b); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_exec_rsp_valid got=%0b exp=0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12) begin failures++; $display("FAIL single_rsp got=v%0b id%0b %0h exp=v1 id0 c", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_idle_rsp_valid got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_tie();
        pulse_reset();
        rsp_ready = 1'b1;
        drive0(1'b1, 32'd10, 32'd3, 5'd0, OP_SUB);
        drive1(1'b1, 32'd1, 32'd2, 5'd0, OP_SLT);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL tie_first_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
        @(negedge clk);
`ifndef ALU_ARB_FIXED_PRIO_EN
        req0_valid = 1'b0;
`endif
        #1;
        checks++; if (req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL tie_exec got=r1 %0b v%0b exp=r1 0 v0", req1_ready, rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd7) begin failures++; $display("FAIL tie_rsp0 got=v%0b id%0b %0h exp=v1 id0 7", rsp_valid, rsp_id, rsp_data); end
        #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL tie_b2b_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
`else
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("FAIL tie_b2b_grant got=%0b%0b exp=01", req0_ready, req1_ready); end
`endif
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL tie_exec2 got=v%0b exp=v0", rsp_valid); end
        @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd7) begin failures++; $display("FAIL tie_rsp1 got=v%0b id%0b %0h exp=v1 id0 7", rsp_valid, rsp_id, rsp_data); end
`else
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd1) begin failures++; $display("FAIL tie_rsp1 got=v%0b id%0b %0h exp=v1 id1 1", rsp_valid, rsp_id, rsp_data); end
`endif
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL tie_idle got=v%0b exp=v0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        drive1(1'b1, 32'd100, 32'd23, 5'd0, OP_ADD);
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_accept1 got=%0b exp=1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        drive0(1'b1, 32'd50, 32'd8, 5'd0, OP_SUB);
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_exec_ready0 got=%0b exp=0", req0_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd123) begin failures++; $display("FAIL bp_hold[%0d] got=v%0b id%0b %0h exp=v1 id1 7b", i, rsp_valid, rsp_id, rsp_data); end
            checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_a !== 32'd100) begin failures++; $display("FAIL bp_stall[%0d] got=%0b%0b alu_a=%0h exp=00 alu_a=64", i, req0_ready, req1_ready, alu_a); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release got=r0 %0b v%0b exp=r0 1 v1", req0_ready, rsp_valid); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || alu_a !== 32'd50) begin failures++; $display("FAIL bp_exec2 got=v%0b alu_a=%0h exp=v0 alu_a=32", rsp_valid, alu_a); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd42) begin failures++; $display("FAIL bp_rsp2 got=v%0b id%0b %0h exp=v1 id0 2a", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_shift_undef();
        @(negedge clk);
        rsp_ready = 1'b1;
        drive1(1'b1, 32'd0, 32'd1, 5'd31, OP_SLL);
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL sll_accept got=%0b exp=1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++; if (alu_shamt !== 5'd31 || alu_op !== OP_SLL) begin failures++; $display("FAIL sll_exec got=sh%0h op%0h exp=sh1f op3", alu_shamt, alu_op); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'h8000_0000) begin failures++; $display("FAIL sll_rsp got=v%0b id%0b %0h exp=v1 id1 80000000", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        drive0(1'b1, 32'd3, 32'd4, 5'd0, OP_BAD);
        #1;
        checks++; if (req0_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bad_accept got=r0 %0b v%0b exp=r0 1 v0", req0_ready, rsp_valid); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (alu_op !== OP_BAD) begin failures++; $display("FAIL bad_op_passthru got=%0h exp=1f", alu_op); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd0) begin failures++; $display("FAIL bad_rsp got=v%0b id%0b %0h exp=v1 id0 0", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        rsp_ready = 1'b1;
        drive0(1'b1, 32'd1, 32'd1, 5'd0, OP_ADD);
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%0b exp=1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (alu_a !== 32'd1) begin failures++; $display("FAIL rmid_exec_alu got=%0h exp=1", alu_a); end
        reset = 1'b1;
        drive0(1'b1, 32'd2, 32'd3, 5'd0, OP_ADD);
        drive1(1'b1, 32'd1, 32'd2, 5'd0, OP_SLT);
        #1;
        checks++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_a !== 32'd0) begin failures++; $display("FAIL rmid_in_reset got=v%0b r%0b%0b alu_a=%0h exp=v0 r00 alu_a=0", rsp_valid, req0_ready, req1_ready, alu_a); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp got=v%0b exp=v0", rsp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL rmid_tie_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_exec got=v%0b exp=v0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd5) begin failures++; $display("FAIL rmid_rsp got=v%0b id%0b %0h exp=v1 id0 5", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_idle got=v%0b exp=v0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_shift_undef();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
